// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared CPU types: register index type and pipeline controller state enum.
// -----------------------------------------------------------------------------
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } pctrl_state_t;

    localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Combinational load-use hazard compare between the load in EX and the
// source registers of the instruction in ID.
// Ports:
//   ex_dren    in   load in EX (ID/EX dMemREN)
//   ex_rt      in   load destination register
//   id_rs      in   ID source register rs
//   id_rt      in   ID source register rt
//   lu_hazard  out  load-use hazard present
// -----------------------------------------------------------------------------
module hazard_detect
    import cpu_types_pkg::*;
(
    input  logic     ex_dren,
    input  regbits_t ex_rt,
    input  regbits_t id_rs,
    input  regbits_t id_rt,
    output logic     lu_hazard
);

    // Register 0 is hardwired to zero, so a load into it never creates a hazard.
    assign lu_hazard = ex_dren && (ex_rt != '0) &&
                       ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Five-stage pipeline stall/flush controller. A small registered state
// (RUN, DWAIT, HALT) plus combinational priority resolution of halt, data
// memory stall, EX redirect, load-use hazard and fetch miss.
//
// Optional feature: define PIPECTRL_PERF_EN to add the stall_cycles port,
// a saturating count of cycles with pc_en=0 outside HALT.
//
// Ports:
//   CLK, nRST                      clock (rising edge), async active-low reset
//   ihit, dhit                     fetch / data access complete this cycle
//   mem_dren, mem_dwen             EX/MEM data read / write request
//   ex_dren, ex_rt                 load in EX and its destination register
//   id_rs, id_rt                   IF/ID source register fields
//   ex_redirect                    taken branch/jump resolved in EX
//   wb_halt                        halt reached writeback
//   pc_en                          PC update enable
//   ifid_en..memwb_en              latch enables
//   ifid_flush..exmem_flush        latch load-bubble
//   halted                         processor halted
//   stall_cycles                   stall cycle count (PIPECTRL_PERF_EN only)
//
// state | meaning
// ------+------------------------------------------------------------
// RUN   | normal operation, full priority resolution each cycle
// DWAIT | waiting on dhit; everything frozen until dhit=1
// HALT  | halted, sticky until reset, all inputs ignored
// -----------------------------------------------------------------------------
module pipeline_ctrl
    import cpu_types_pkg::*;
(
    input  logic       CLK,
    input  logic       nRST,
    input  logic       ihit,
    input  logic       dhit,
    input  logic       mem_dren,
    input  logic       mem_dwen,
    input  logic       ex_dren,
    input  regbits_t   ex_rt,
    input  regbits_t   id_rs,
    input  regbits_t   id_rt,
    input  logic       ex_redirect,
    input  logic       wb_halt,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       idex_en,
    output logic       exmem_en,
    output logic       memwb_en,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       exmem_flush,
    output logic       halted
`ifdef PIPECTRL_PERF_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    pctrl_state_t state, state_next;
    logic         lu_hazard;
    logic         mem_req;
    logic         halt_req;
    logic         use_run;

    hazard_detect u_hazard_detect (
        .ex_dren   (ex_dren),
        .ex_rt     (ex_rt),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .lu_hazard (lu_hazard)
    );

    assign mem_req  = mem_dren || mem_dwen;
    // While reset is held the controller reports not-halted even if a halt
    // is sitting in writeback.
    assign halt_req = wb_halt && nRST;
    // DWAIT with dhit=1 resolves exactly like RUN in the same cycle.
    assign use_run  = (state == RUN) || ((state == DWAIT) && dhit);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        halted      = 1'b0;

        if (use_run) begin
            if (halt_req) begin
                halted     = 1'b1;
                state_next = HALT;
            end else if (mem_req && !dhit) begin
                state_next = DWAIT;
            end else begin
                state_next = RUN;
                ifid_en    = 1'b1;
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
                if (ex_redirect) begin
                    // Without ihit the PC holds; the target is kept upstream.
                    pc_en      = ihit;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (lu_hazard) begin
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end else if (!ihit) begin
                    ifid_flush = 1'b1;
                end else begin
                    pc_en = 1'b1;
                end
            end
        end else if (state == HALT) begin
            halted = 1'b1;
        end
    end

`ifdef PIPECTRL_PERF_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
        end else if (!pc_en && (state != HALT) && (stall_cnt != STALL_CNT_MAX)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
// Directed bench for pipeline_ctrl. Inputs change on the falling edge and
// outputs are sampled 1 time unit later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

    logic       CLK;
    logic       nRST;
    logic       ihit, dhit, mem_dren, mem_dwen, ex_dren, ex_redirect, wb_halt;
    logic [4:0] ex_rt, id_rs, id_rt;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, exmem_flush, halted;
`ifdef PIPECTRL_PERF_EN
    logic [31:0] stall_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_f, idex_f, exmem_f, halted}
    localparam logic [8:0] O_NORM   = 9'b11111_000_0;
    localparam logic [8:0] O_LU     = 9'b00111_010_0;
    localparam logic [8:0] O_FMISS  = 9'b01111_100_0;
    localparam logic [8:0] O_REDIR  = 9'b11111_110_0;
    localparam logic [8:0] O_REDIRN = 9'b01111_110_0;
    localparam logic [8:0] O_STALL  = 9'b00000_000_0;
    localparam logic [8:0] O_HALT   = 9'b00000_000_1;

    logic [8:0] outs;
    assign outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                   ifid_flush, idex_flush, exmem_flush, halted};

    pipeline_ctrl dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ihit        (ihit),
        .dhit        (dhit),
        .mem_dren    (mem_dren),
        .mem_dwen    (mem_dwen),
        .ex_dren     (ex_dren),
        .ex_rt       (ex_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_redirect (ex_redirect),
        .wb_halt     (wb_halt),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .idex_en     (idex_en),
        .exmem_en    (exmem_en),
        .memwb_en    (memwb_en),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .exmem_flush (exmem_flush),
        .halted      (halted)
`ifdef PIPECTRL_PERF_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input logic i_ihit, input logic i_dhit, input logic i_dren,
                          input logic i_dwen, input logic i_exdren, input logic [4:0] i_exrt,
                          input logic [4:0] i_rs, input logic [4:0] i_rt,
                          input logic i_redir, input logic i_halt);
        ihit = i_ihit; dhit = i_dhit; mem_dren = i_dren; mem_dwen = i_dwen;
        ex_dren = i_exdren; ex_rt = i_exrt; id_rs = i_rs; id_rt = i_rt;
        ex_redirect = i_redir; wb_halt = i_halt;
    endtask

    task automatic set_norm();
        set_in(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    endtask

    task automatic chk_out(input string tag, input logic [8:0] exp);
        #1;
        check_eq(tag, {23'd0, outs}, {23'd0, exp});
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    initial begin
        nRST = 1'b0;
        set_norm();
        tick();
        chk_out("reset_outputs", O_NORM);
`ifdef PIPECTRL_PERF_EN
        check_eq("reset_stall_cnt", stall_cycles, 32'd0);
`endif
        nRST = 1'b1;
        chk_out("normal", O_NORM);
        tick();

        // load-use via rs, one cycle, then clears
        set_in(1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0);
        chk_out("lu_rs", O_LU);
        tick();
        set_norm();
        chk_out("lu_clear", O_NORM);
        tick();
        // load into r0 never stalls
        set_in(1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0);
        chk_out("lu_r0", O_NORM);
        tick();
        // load-use via rt
        set_in(1, 0, 0, 0, 1, 5'd7, 5'd3, 5'd7, 0, 0);
        chk_out("lu_rt", O_LU);
        tick();
        // load without register match
        set_in(1, 0, 0, 0, 1, 5'd7, 5'd3, 5'd4, 0, 0);
        chk_out("lu_nomatch", O_NORM);
        tick();
        // fetch miss
        set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        chk_out("fetch_miss", O_FMISS);
        tick();
        // load-use beats fetch miss
        set_in(0, 0, 0, 0, 1, 5'd9, 5'd9, 5'd0, 0, 0);
        chk_out("lu_over_fmiss", O_LU);
        tick();
        // redirect with and without ihit
        set_in(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0);
        chk_out("redirect", O_REDIR);
        tick();
        set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0);
        chk_out("redirect_nohit", O_REDIRN);
        tick();
        // redirect beats load-use
        set_in(1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0);
        chk_out("redirect_over_lu", O_REDIR);
        tick();
        // mem access that completes immediately: no stall
        set_in(1, 1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        chk_out("mem_hit", O_NORM);
        tick();

        // mem stall: 3 cycles of dhit=0, then dhit=1
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0);
            chk_out($sformatf("mem_stall_%0d", i), O_STALL);
            tick();
        end
        set_in(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        chk_out("mem_release", O_NORM);
        tick();
        set_norm();
        chk_out("mem_back_run", O_NORM);
        tick();

        // DWAIT ignores request drop and halt while dhit=0; dhit=1 resolves halt
        set_in(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        chk_out("dwait_enter", O_STALL);
        tick();
        set_in(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
        chk_out("dwait_hold", O_STALL);
        tick();
        set_in(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
        chk_out("dwait_to_halt", O_HALT);
        tick();

        // HALT is sticky regardless of inputs
        for (int i = 0; i < 10; i++) begin
            ihit = 1'($urandom); dhit = 1'($urandom); mem_dren = 1'($urandom);
            mem_dwen = 1'($urandom); ex_dren = 1'($urandom); ex_rt = 5'($urandom);
            id_rs = 5'($urandom); id_rt = 5'($urandom);
            ex_redirect = 1'($urandom); wb_halt = 1'($urandom);
            chk_out($sformatf("halt_sticky_%0d", i), O_HALT);
            tick();
        end
        set_norm();
        chk_out("halt_quiet", O_HALT);
        nRST = 1'b0;
        chk_out("halt_reset_async", O_NORM);
        tick();
        nRST = 1'b1;
        chk_out("halt_reset_release", O_NORM);
        tick();
        chk_out("after_halt_run", O_NORM);
        tick();

        // reset in the middle of DWAIT
        set_in(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        chk_out("rst_dwait_enter", O_STALL);
        tick();
        set_in(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        chk_out("rst_dwait_hold", O_STALL);
        tick();
        nRST = 1'b0;
        chk_out("rst_dwait_async", O_NORM);
`ifdef PIPECTRL_PERF_EN
        check_eq("rst_dwait_cnt", stall_cycles, 32'd0);
`endif
        tick();
        nRST = 1'b1;
        chk_out("rst_dwait_run", O_NORM);
        tick();

        // 4 fetch misses then a 3-cycle data stall
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
            chk_out($sformatf("perf_fmiss_%0d", i), O_FMISS);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
            chk_out($sformatf("perf_stall_%0d", i), O_STALL);
            tick();
        end
        set_in(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        chk_out("perf_release", O_NORM);
        tick();
        set_norm();
        #1;
`ifdef PIPECTRL_PERF_EN
        check_eq("perf_stall_cnt", stall_cycles, 32'd7);
        // halt entry cycle counts, HALT cycles do not
        wb_halt = 1'b1;
        tick();
        wb_halt = 1'b0;
        tick();
        tick();
        #1;
        check_eq("perf_halt_cnt", stall_cycles, 32'd8);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL use reset nRST, asynchronous, active-low; clock CLK.
REQ-002 CLK  in  1  pipeline clock, rising edge.
REQ-003 nRST  in  1  asynchronous active-low reset.
REQ-004 ihit  in  1  instruction fetch complete this cycle.
REQ-005 dhit  in  1  data access complete this cycle.
REQ-006 mem_dren, mem_dwen  in  1 each  EX/MEM latch data read/write requests.
REQ-007 ex_dren  in  1  ID/EX latch dMemREN output (load in EX).
REQ-008 ex_rt  in  5  ID/EX latch rt output (load destination).
REQ-009 id_rs, id_rt  in  5 each  source register fields of instruction in IF/ID.
REQ-010 ex_redirect  in  1  taken branch, jump or jump-register resolved in EX.
REQ-011 wb_halt  in  1  halt instruction reached writeback.
REQ-012 pc_en  out  1  PC update enable.
REQ-013 ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables.
REQ-014 ifid_flush, idex_flush, exmem_flush  out  1 each  latch load-bubble (zero all fields, as latch reset).
REQ-015 halted  out  1  processor halted.
REQ-016 stall_cycles  out  32  stall cycle count (present only under PIPECTRL_PERF_EN).

Function
REQ-017 SHALL hold a registered state: RUN, DWAIT, HALT; all outputs combinational from state and inputs, zero added latency.
REQ-018 In RUN, conditions SHALL resolve by priority: halt > mem stall > redirect > load-use > fetch miss > normal.
REQ-019 Halt: wb_halt=1 -> all enables and flushes 0, halted=1, next state HALT.
REQ-020 Mem stall: (mem_dren|mem_dwen)&!dhit -> all enables 0, flushes 0, next state DWAIT.
REQ-021 Redirect: ex_redirect=1 -> pc_en=ihit, all latch enables 1, ifid_flush=1, idex_flush=1.
REQ-022 Redirect with ihit=0: ifid_flush still 1; PC held; target retained upstream, not this block's concern.
REQ-023 Load-use: ex_dren & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt) -> pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=memwb_en=1.
REQ-024 Fetch miss: ihit=0 -> pc_en=0, ifid_en=1, ifid_flush=1, downstream enables 1.
REQ-025 Normal: all enables 1, all flushes 0, halted=0.
REQ-026 DWAIT: dhit=0 -> all enables 0, stay; dhit=1 -> outputs evaluated exactly as RUN priority (halt..normal) that cycle, next state per RUN rules.
REQ-027 HALT: sticky until reset; all enables/flushes 0, halted=1, all inputs ignored.
REQ-028 ex_rt=0 SHALL never trigger load-use; mem_dren and mem_dwen both 1 treated as one request.
REQ-029 A flush SHALL only be asserted together with its latch enable=1.

Reset
REQ-030 nRST low SHALL force state RUN, stall_cycles 0, immediately (asynchronous), including mid-DWAIT or HALT.
REQ-031 During reset outputs SHALL reflect RUN-state evaluation of inputs; halted=0.

Configuration
REQ-032 Macro PIPECTRL_PERF_EN defined: stall_cycles increments each cycle with pc_en=0 and state!=HALT, saturating at 32'hFFFFFFFF.
REQ-033 Macro undefined: stall_cycles port and counter absent; all other behaviour identical.

Structure
REQ-034 cpu_types_pkg SHALL gain pctrl_state_t enum (RUN, DWAIT, HALT); register indices use existing regbits_t.
REQ-035 Load-use compare SHALL be sub-module hazard_detect (combinational, ex_dren/ex_rt/id_rs/id_rt -> lu_hazard).

Verification
REQ-036 Load-use: ex_dren=1, ex_rt=5, id_rs=5, ihit=1 -> pc_en=0, ifid_en=0, idex_flush=1 one cycle; ex_rt=0,id_rs=0 -> no stall.
REQ-037 Mem stall: mem_dren=1, dhit=0 for 3 cycles then 1 -> enables 0 for 3 cycles in DWAIT, 4th cycle all enables 1, state RUN.
REQ-038 Redirect+load-use same cycle: ex_redirect=1, hazard true -> ifid_flush=1, idex_flush=1, pc_en=1, no hold.
REQ-039 Halt: wb_halt=1 one cycle, then toggle all inputs 10 cycles -> halted=1, all enables 0 throughout; nRST pulse -> RUN.
REQ-040 Reset mid-DWAIT: assert nRST low in DWAIT -> state RUN same cycle, stall_cycles=0.
REQ-041 PIPECTRL_PERF_EN: 4 fetch-miss cycles + 3 DWAIT cycles -> stall_cycles=7.
